// File: rtl/idli_pkg.sv
// Shared types and constants for the IDLI quad-SPI (SQI) memory controller.
package idli_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } sqi_state_t;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam int         CMD_NIB  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// Word-wide nibble shift register: parallel load, MS-nibble out, nibble shift-in at the LS end.
module idli_sqi_shift_m #(
  parameter int DATA_W = 16
) (
  input  logic              gck,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic [3:0]        nib_in,
  output logic [DATA_W-1:0] q_nxt,
  output logic [3:0]        ms_nib
);

  logic [DATA_W-1:0] q;

  // q_nxt is the value after one more shift; the top level captures completed read words from it.
  generate
    if (DATA_W == 4) begin : g_single_nib
      assign q_nxt = nib_in;
    end else begin : g_multi_nib
      assign q_nxt = {q[DATA_W-5:0], nib_in};
    end
  endgenerate

  assign ms_nib = q[DATA_W-1 -: 4];

  always_ff @(posedge gck) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory controller: one request becomes opcode, address, optional dummy and a burst of
// nibble-serial data words to one of NUM_CS memories.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int NUM_CS    = 2,
  parameter int DUMMY_CYC = 2,
  parameter int LEN_W     = 4
) (
  input  logic                                        i_sqi_gck,
  input  logic                                        i_sqi_rst,
  input  logic                                        i_sqi_req_vld,
  output logic                                        o_sqi_req_rdy,
  input  logic                                        i_sqi_req_wr,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] i_sqi_req_cs,
  input  logic [ADDR_W-1:0]                           i_sqi_req_addr,
  input  logic [LEN_W-1:0]                            i_sqi_req_len,
  input  logic [DATA_W-1:0]                           i_sqi_wr_data,
  output logic                                        o_sqi_wr_rdy,
  output logic [DATA_W-1:0]                           o_sqi_rd_data,
  output logic                                        o_sqi_rd_vld,
  output logic                                        o_sqi_busy,
  output logic [NUM_CS-1:0]                           o_sqi_cs_n,
  output logic                                        o_sqi_sck_en,
  output logic                                        o_sqi_oe,
  output logic [3:0]                                  o_sqi_data,
  input  logic [3:0]                                  i_sqi_data
);

  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int ADDR_NIB = ADDR_W / 4;
  localparam int WORD_NIB = DATA_W / 4;
  localparam int HDR_W    = 8 + ADDR_W;
  localparam int MAX_PH   = max_int(max_int(CMD_NIB, ADDR_NIB), max_int(DUMMY_CYC, WORD_NIB));
  localparam int NIB_W    = $clog2(MAX_PH);

  localparam logic [NIB_W-1:0] CMD_LAST   = NIB_W'(CMD_NIB - 1);
  localparam logic [NIB_W-1:0] ADDR_LAST  = NIB_W'(ADDR_NIB - 1);
  localparam logic [NIB_W-1:0] WORD_LAST  = NIB_W'(WORD_NIB - 1);
  localparam logic [NIB_W-1:0] DUMMY_LAST = NIB_W'((DUMMY_CYC == 0) ? 0 : DUMMY_CYC - 1);

  sqi_state_t        state;
  logic [NIB_W-1:0]  nib_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic              wr_q;
  logic [CS_W-1:0]   cs_q;
  logic [LEN_W-1:0]  len_q;
  logic [HDR_W-1:0]  hdr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  logic              accept;
  logic              cs_active;
  logic              wr_fire;
  logic              rd_last;
  logic [DATA_W-1:0] sh_nxt;
  logic [3:0]        sh_ms;

  // Request handshake: a request transfers on the rising edge where i_sqi_req_vld and
  // o_sqi_req_rdy are both high; ready is high only in IDLE, so a held valid is taken once per
  // IDLE visit and ignored while busy. Write words have no stall: the word on i_sqi_wr_data is
  // captured on every edge that ends a cycle with o_sqi_wr_rdy high.
  assign accept    = i_sqi_req_vld && (state == ST_IDLE);
  assign cs_active = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DUMMY) || (state == ST_DATA);

  assign wr_fire = wr_q && (((state == ST_ADDR) && (nib_cnt == ADDR_LAST)) ||
                            ((state == ST_DATA) && (nib_cnt == WORD_LAST) && (word_cnt != len_q)));
  assign rd_last = !wr_q && (state == ST_DATA) && (nib_cnt == WORD_LAST);

  idli_sqi_shift_m #(
    .DATA_W (DATA_W)
  ) u_shift (
    .gck       (i_sqi_gck),
    .rst       (i_sqi_rst),
    .load      (wr_fire),
    .load_data (i_sqi_wr_data),
    .shift_en  (state == ST_DATA),
    .nib_in    (i_sqi_data),
    .q_nxt     (sh_nxt),
    .ms_nib    (sh_ms)
  );

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state     <= ST_IDLE;
      nib_cnt   <= '0;
      word_cnt  <= '0;
      wr_q      <= 1'b0;
      cs_q      <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_last;
      if (rd_last) begin
        rd_data_q <= sh_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_q     <= i_sqi_req_wr;
            cs_q     <= i_sqi_req_cs;
            len_q    <= i_sqi_req_len;
            hdr_q    <= {(i_sqi_req_wr ? OP_WRITE : OP_READ), i_sqi_req_addr};
            nib_cnt  <= '0;
            word_cnt <= '0;
            state    <= ST_CMD;
          end
        end
        ST_CMD: begin
          hdr_q <= {hdr_q[HDR_W-5:0], 4'h0};
          if (nib_cnt == CMD_LAST) begin
            nib_cnt <= '0;
            state   <= ST_ADDR;
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
        end
        ST_ADDR: begin
          hdr_q <= {hdr_q[HDR_W-5:0], 4'h0};
          if (nib_cnt == ADDR_LAST) begin
            nib_cnt <= '0;
            state   <= (!wr_q && (DUMMY_CYC != 0)) ? ST_DUMMY : ST_DATA;
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
        end
        ST_DUMMY: begin
          if (nib_cnt == DUMMY_LAST) begin
            nib_cnt <= '0;
            state   <= ST_DATA;
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
        end
        ST_DATA: begin
          if (nib_cnt == WORD_LAST) begin
            nib_cnt <= '0;
            // Compare before incrementing so len all-ones runs 2^LEN_W words without wrapping.
            if (word_cnt == len_q) begin
              state <= ST_DONE;
            end else begin
              word_cnt <= word_cnt + LEN_W'(1);
            end
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_sqi_cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_active && (cs_q == CS_W'(i))) begin
        o_sqi_cs_n[i] = 1'b0;
      end
    end
  end

  assign o_sqi_req_rdy = (state == ST_IDLE);
  assign o_sqi_busy    = (state != ST_IDLE);
  assign o_sqi_sck_en  = cs_active;
  assign o_sqi_oe      = (state == ST_CMD) || (state == ST_ADDR) || ((state == ST_DATA) && wr_q);
  assign o_sqi_data    = !o_sqi_oe ? 4'h0 :
                         (state == ST_DATA) ? sh_ms : hdr_q[HDR_W-1 -: 4];
  assign o_sqi_wr_rdy  = wr_fire;
  assign o_sqi_rd_data = rd_data_q;
  assign o_sqi_rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: cycle-exact write/read/burst/reset/back-to-back scenarios.
module tb_idli_sqi_ctrl_m;

  logic        i_sqi_gck;
  logic        i_sqi_rst;
  logic        i_sqi_req_vld;
  logic        o_sqi_req_rdy;
  logic        i_sqi_req_wr;
  logic [0:0]  i_sqi_req_cs;
  logic [15:0] i_sqi_req_addr;
  logic [3:0]  i_sqi_req_len;
  logic [15:0] i_sqi_wr_data;
  logic        o_sqi_wr_rdy;
  logic [15:0] o_sqi_rd_data;
  logic        o_sqi_rd_vld;
  logic        o_sqi_busy;
  logic [1:0]  o_sqi_cs_n;
  logic        o_sqi_sck_en;
  logic        o_sqi_oe;
  logic [3:0]  o_sqi_data;
  logic [3:0]  i_sqi_data;

  int n_checks = 0;
  int n_errors = 0;

  idli_sqi_ctrl_m #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .NUM_CS    (2),
    .DUMMY_CYC (2),
    .LEN_W     (4)
  ) dut (
    .i_sqi_gck      (i_sqi_gck),
    .i_sqi_rst      (i_sqi_rst),
    .i_sqi_req_vld  (i_sqi_req_vld),
    .o_sqi_req_rdy  (o_sqi_req_rdy),
    .i_sqi_req_wr   (i_sqi_req_wr),
    .i_sqi_req_cs   (i_sqi_req_cs),
    .i_sqi_req_addr (i_sqi_req_addr),
    .i_sqi_req_len  (i_sqi_req_len),
    .i_sqi_wr_data  (i_sqi_wr_data),
    .o_sqi_wr_rdy   (o_sqi_wr_rdy),
    .o_sqi_rd_data  (o_sqi_rd_data),
    .o_sqi_rd_vld   (o_sqi_rd_vld),
    .o_sqi_busy     (o_sqi_busy),
    .o_sqi_cs_n     (o_sqi_cs_n),
    .o_sqi_sck_en   (o_sqi_sck_en),
    .o_sqi_oe       (o_sqi_oe),
    .o_sqi_data     (o_sqi_data),
    .i_sqi_data     (i_sqi_data)
  );

  // clock / reset
  initial i_sqi_gck = 1'b0;
  always #5 i_sqi_gck = ~i_sqi_gck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge
  task automatic tick();
    @(posedge i_sqi_gck);
    #1;
  endtask

  task automatic smp();
    @(negedge i_sqi_gck);
  endtask

  task automatic test_reset();
    i_sqi_rst = 1'b1;
    tick();
    tick();
    smp();
    n_checks++; if (o_sqi_req_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_req_rdy got=%b exp=1", o_sqi_req_rdy); end
    n_checks++; if (o_sqi_cs_n !== 2'b11) begin n_errors++; $display("FAIL reset_cs_n got=%b exp=11", o_sqi_cs_n); end
    n_checks++; if (o_sqi_sck_en !== 1'b0) begin n_errors++; $display("FAIL reset_sck_en got=%b exp=0", o_sqi_sck_en); end
    n_checks++; if (o_sqi_oe !== 1'b0) begin n_errors++; $display("FAIL reset_oe got=%b exp=0", o_sqi_oe); end
    n_checks++; if (o_sqi_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", o_sqi_busy); end
    n_checks++; if (o_sqi_rd_vld !== 1'b0) begin n_errors++; $display("FAIL reset_rd_vld got=%b exp=0", o_sqi_rd_vld); end
    n_checks++; if (o_sqi_wr_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_wr_rdy got=%b exp=0", o_sqi_wr_rdy); end
    n_checks++; if (o_sqi_rd_data !== 16'h0000) begin n_errors++; $display("FAIL reset_rd_data got=%h exp=0000", o_sqi_rd_data); end
    n_checks++; if (o_sqi_data !== 4'h0) begin n_errors++; $display("FAIL reset_data got=%h exp=0", o_sqi_data); end
    tick();
    i_sqi_rst = 1'b0;
  endtask

  task automatic test_write_single();
    logic [3:0] exp_q[$];
    logic [3:0] exp_nib;
    exp_q = '{4'h0, 4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hE, 4'hE, 4'hF};
    tick();
    i_sqi_req_vld = 1'b1; i_sqi_req_wr = 1'b1; i_sqi_req_cs = 1'b1;
    i_sqi_req_addr = 16'h1234; i_sqi_req_len = 4'h0; i_sqi_wr_data = 16'hBEEF;
    smp();
    n_checks++; if (o_sqi_req_rdy !== 1'b1) begin n_errors++; $display("FAIL wr_c0_req_rdy got=%b exp=1", o_sqi_req_rdy); end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) i_sqi_req_vld = 1'b0;
      smp();
      n_checks++; if (o_sqi_wr_rdy !== (cyc == 6)) begin n_errors++; $display("FAIL wr_wr_rdy cyc=%0d got=%b exp=%b", cyc, o_sqi_wr_rdy, cyc == 6); end
      if (cyc <= 10) begin
        exp_nib = exp_q.pop_front();
        n_checks++; if (o_sqi_data !== exp_nib) begin n_errors++; $display("FAIL wr_data cyc=%0d got=%h exp=%h", cyc, o_sqi_data, exp_nib); end
        n_checks++; if (o_sqi_cs_n !== 2'b01) begin n_errors++; $display("FAIL wr_cs_n cyc=%0d got=%b exp=01", cyc, o_sqi_cs_n); end
        n_checks++; if (o_sqi_oe !== 1'b1) begin n_errors++; $display("FAIL wr_oe cyc=%0d got=%b exp=1", cyc, o_sqi_oe); end
      end
      if (cyc == 11) begin
        n_checks++; if (o_sqi_cs_n !== 2'b11) begin n_errors++; $display("FAIL wr_done_cs_n got=%b exp=11", o_sqi_cs_n); end
        n_checks++; if (o_sqi_sck_en !== 1'b0) begin n_errors++; $display("FAIL wr_done_sck_en got=%b exp=0", o_sqi_sck_en); end
        n_checks++; if (o_sqi_busy !== 1'b1) begin n_errors++; $display("FAIL wr_done_busy got=%b exp=1", o_sqi_busy); end
      end
      n_checks++; if (o_sqi_req_rdy !== (cyc == 12)) begin n_errors++; $display("FAIL wr_req_rdy cyc=%0d got=%b exp=%b", cyc, o_sqi_req_rdy, cyc == 12); end
    end
  endtask

  task automatic test_read_single();
    logic [3:0]  hdr_exp [6];
    logic [15:0] mem_word;
    hdr_exp  = '{4'h0, 4'h3, 4'h0, 4'h0, 4'hA, 4'h0};
    mem_word = 16'hC0DE;
    tick();
    i_sqi_req_vld = 1'b1; i_sqi_req_wr = 1'b0; i_sqi_req_cs = 1'b0;
    i_sqi_req_addr = 16'h00A0; i_sqi_req_len = 4'h0;
    smp();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      if (cyc == 1) i_sqi_req_vld = 1'b0;
      i_sqi_data = (cyc >= 9 && cyc <= 12) ? 4'((mem_word >> (4 * (12 - cyc))) & 16'hF) : 4'h5;
      smp();
      if (cyc <= 6) begin
        n_checks++; if (o_sqi_data !== hdr_exp[cyc-1]) begin n_errors++; $display("FAIL rd_hdr cyc=%0d got=%h exp=%h", cyc, o_sqi_data, hdr_exp[cyc-1]); end
      end
      n_checks++; if (o_sqi_oe !== (cyc <= 6)) begin n_errors++; $display("FAIL rd_oe cyc=%0d got=%b exp=%b", cyc, o_sqi_oe, cyc <= 6); end
      if (cyc >= 7 && cyc <= 12) begin
        n_checks++; if (o_sqi_data !== 4'h0) begin n_errors++; $display("FAIL rd_data_released cyc=%0d got=%h exp=0", cyc, o_sqi_data); end
      end
      n_checks++; if (o_sqi_sck_en !== (cyc <= 12)) begin n_errors++; $display("FAIL rd_sck_en cyc=%0d got=%b exp=%b", cyc, o_sqi_sck_en, cyc <= 12); end
      n_checks++; if (o_sqi_cs_n !== ((cyc <= 12) ? 2'b10 : 2'b11)) begin n_errors++; $display("FAIL rd_cs_n cyc=%0d got=%b", cyc, o_sqi_cs_n); end
      n_checks++; if (o_sqi_rd_vld !== (cyc == 13)) begin n_errors++; $display("FAIL rd_vld cyc=%0d got=%b exp=%b", cyc, o_sqi_rd_vld, cyc == 13); end
      if (cyc == 13) begin
        n_checks++; if (o_sqi_rd_data !== 16'hC0DE) begin n_errors++; $display("FAIL rd_word got=%h exp=C0DE", o_sqi_rd_data); end
      end
      n_checks++; if (o_sqi_req_rdy !== (cyc == 14)) begin n_errors++; $display("FAIL rd_req_rdy cyc=%0d got=%b exp=%b", cyc, o_sqi_req_rdy, cyc == 14); end
    end
  endtask

  task automatic test_read_burst();
    logic [15:0] words [4];
    logic [15:0] w;
    int          pulses;
    int          idx;
    words  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    pulses = 0;
    tick();
    i_sqi_req_vld = 1'b1; i_sqi_req_wr = 1'b0; i_sqi_req_cs = 1'b1;
    i_sqi_req_addr = 16'h4000; i_sqi_req_len = 4'h3;
    smp();
    for (int cyc = 1; cyc <= 26; cyc++) begin
      tick();
      if (cyc == 1) i_sqi_req_vld = 1'b0;
      if (cyc >= 9 && cyc <= 24) begin
        w = words[(cyc - 9) / 4];
        i_sqi_data = 4'((w >> (4 * (3 - ((cyc - 9) % 4)))) & 16'hF);
      end else begin
        i_sqi_data = 4'hA;
      end
      smp();
      if (cyc <= 24) begin
        n_checks++; if (o_sqi_cs_n !== 2'b01) begin n_errors++; $display("FAIL burst_cs_n cyc=%0d got=%b exp=01", cyc, o_sqi_cs_n); end
      end
      n_checks++;
      if (o_sqi_rd_vld !== (cyc >= 13 && cyc <= 25 && ((cyc - 13) % 4) == 0)) begin
        n_errors++; $display("FAIL burst_rd_vld cyc=%0d got=%b", cyc, o_sqi_rd_vld);
      end
      if (o_sqi_rd_vld === 1'b1) begin
        idx = pulses;
        pulses++;
        if (idx < 4) begin
          n_checks++; if (o_sqi_rd_data !== words[idx]) begin n_errors++; $display("FAIL burst_word%0d got=%h exp=%h", idx, o_sqi_rd_data, words[idx]); end
        end
      end
      if (cyc == 15) begin
        n_checks++; if (o_sqi_rd_data !== 16'h1234) begin n_errors++; $display("FAIL burst_hold got=%h exp=1234", o_sqi_rd_data); end
      end
    end
    n_checks++; if (pulses != 4) begin n_errors++; $display("FAIL burst_pulse_count got=%0d exp=4", pulses); end
  endtask

  task automatic test_reset_mid_write();
    tick();
    i_sqi_req_vld = 1'b1; i_sqi_req_wr = 1'b1; i_sqi_req_cs = 1'b0;
    i_sqi_req_addr = 16'h1234; i_sqi_req_len = 4'h2; i_sqi_wr_data = 16'hBEEF;
    smp();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) i_sqi_req_vld = 1'b0;
      if (cyc == 5) i_sqi_rst = 1'b1;
      if (cyc == 6) i_sqi_rst = 1'b0;
      smp();
      if (cyc < 5) begin
        n_checks++; if (o_sqi_cs_n !== 2'b10) begin n_errors++; $display("FAIL rstmid_pre_cs_n cyc=%0d got=%b exp=10", cyc, o_sqi_cs_n); end
      end
      if (cyc == 6) begin
        n_checks++; if (o_sqi_cs_n !== 2'b11) begin n_errors++; $display("FAIL rstmid_cs_n got=%b exp=11", o_sqi_cs_n); end
        n_checks++; if (o_sqi_req_rdy !== 1'b1) begin n_errors++; $display("FAIL rstmid_req_rdy got=%b exp=1", o_sqi_req_rdy); end
        n_checks++; if (o_sqi_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", o_sqi_busy); end
        n_checks++; if (o_sqi_rd_data !== 16'h0000) begin n_errors++; $display("FAIL rstmid_rd_data got=%h exp=0000", o_sqi_rd_data); end
      end
      if (cyc >= 6) begin
        n_checks++; if (o_sqi_wr_rdy !== 1'b0) begin n_errors++; $display("FAIL rstmid_wr_rdy cyc=%0d got=%b exp=0", cyc, o_sqi_wr_rdy); end
        n_checks++; if (o_sqi_oe !== 1'b0) begin n_errors++; $display("FAIL rstmid_oe cyc=%0d got=%b exp=0", cyc, o_sqi_oe); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    tick();
    i_sqi_req_vld = 1'b1; i_sqi_req_wr = 1'b1; i_sqi_req_cs = 1'b1;
    i_sqi_req_addr = 16'hFFF0; i_sqi_req_len = 4'h0; i_sqi_wr_data = 16'h1357;
    for (int cyc = 0; cyc <= 23; cyc++) begin
      if (cyc > 0) tick();
      smp();
      if (i_sqi_req_vld && o_sqi_req_rdy) acc++;
      n_checks++; if (o_sqi_busy !== ((cyc % 12) != 0)) begin n_errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, o_sqi_busy, (cyc % 12) != 0); end
    end
    tick();
    i_sqi_req_vld = 1'b0;
    smp();
    n_checks++; if (acc != 2) begin n_errors++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
    n_checks++; if (o_sqi_req_rdy !== 1'b1) begin n_errors++; $display("FAIL b2b_idle_rdy got=%b exp=1", o_sqi_req_rdy); end
    tick();
    smp();
    n_checks++; if (o_sqi_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_no_extra got=%b exp=0", o_sqi_busy); end
  endtask

  task automatic test_long_burst_write();
    int         k;
    int         wr_cnt;
    logic       upd;
    logic [3:0] kn;
    logic [3:0] exp_nib;
    k = 0; wr_cnt = 0; upd = 1'b0;
    tick();
    i_sqi_req_vld = 1'b1; i_sqi_req_wr = 1'b1; i_sqi_req_cs = 1'b0;
    i_sqi_req_addr = 16'h0000; i_sqi_req_len = 4'hF; i_sqi_wr_data = 16'h0000;
    smp();
    for (int cyc = 1; cyc <= 72; cyc++) begin
      tick();
      if (cyc == 1) i_sqi_req_vld = 1'b0;
      if (upd) begin
        k++;
        kn = k[3:0];
        i_sqi_wr_data = {4{kn}};
        upd = 1'b0;
      end
      smp();
      n_checks++;
      if (o_sqi_wr_rdy !== (cyc == 6 || (cyc >= 10 && cyc <= 66 && ((cyc - 10) % 4) == 0))) begin
        n_errors++; $display("FAIL long_wr_rdy cyc=%0d got=%b", cyc, o_sqi_wr_rdy);
      end
      if (o_sqi_wr_rdy === 1'b1) begin
        wr_cnt++;
        upd = 1'b1;
      end
      if (cyc >= 7 && cyc <= 70) begin
        exp_nib = 4'((cyc - 7) / 4);
        n_checks++; if (o_sqi_data !== exp_nib || o_sqi_oe !== 1'b1) begin n_errors++; $display("FAIL long_data cyc=%0d got=%h oe=%b exp=%h", cyc, o_sqi_data, o_sqi_oe, exp_nib); end
      end
      n_checks++; if (o_sqi_busy !== (cyc <= 71)) begin n_errors++; $display("FAIL long_busy cyc=%0d got=%b exp=%b", cyc, o_sqi_busy, cyc <= 71); end
      n_checks++; if (o_sqi_req_rdy !== (cyc == 72)) begin n_errors++; $display("FAIL long_req_rdy cyc=%0d got=%b exp=%b", cyc, o_sqi_req_rdy, cyc == 72); end
    end
    n_checks++; if (wr_cnt != 16) begin n_errors++; $display("FAIL long_wr_count got=%0d exp=16", wr_cnt); end
  endtask

  initial begin
    i_sqi_rst      = 1'b1;
    i_sqi_req_vld  = 1'b0;
    i_sqi_req_wr   = 1'b0;
    i_sqi_req_cs   = 1'b0;
    i_sqi_req_addr = '0;
    i_sqi_req_len  = '0;
    i_sqi_wr_data  = '0;
    i_sqi_data     = '0;
    test_reset();
    test_write_single();
    test_read_single();
    test_read_burst();
    test_reset_mid_write();
    test_back_to_back();
    test_long_burst_write();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
